kbd_matrix_scan: RTL
====================

# kbd_matrix_scan

Parametrised keyboard matrix scanner for the calculator cores. It drives COLS open-drain column lines one at a time and samples ROWS active-low row inputs. Each key is debounced independently, and press/release transitions are queued as key-code events in a small FIFO with a valid/ready handshake. It sits between the board-level column/row pins in the top wrapper and the calculator's keyboard logic or trace UART. It replaces the fixed 11-column, 2×4-row hard-wired arrangement with one generic engine.

## Interface
- COLS, 11: number of column lines (2..32)
- ROWS, 4: number of row inputs (1..8)
- SCAN_DIV, 16: clocks a column is driven before rows are sampled (≥4)
- DEBOUNCE, 3: consecutive frames a changed raw state must persist (1..15)
- FIFO_DEPTH, 4: event FIFO entries (power of two, ≥2)
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- col_oe_o  output  COLS  1 = drive that column low; 0 = hi-Z. The wrapper forms the inout pin.
- rows_in  input  ROWS  row lines, active-low (pulled up externally), asynchronous
- evt_valid_o  output  1  event available
- evt_ready_in  input  1  consumer accepts event
- evt_code_o  output  $clog2(COLS*ROWS)  key code = col*ROWS + row
- evt_press_o  output  1  1 = press, 0 = release
- any_key_o  output  1  OR of all debounced key states
- ovf_o  output  1  sticky: an event was dropped
- ovf_clr_in  input  1  synchronous clear of ovf_o

## Operation
- Rows pass through a 2-flop synchroniser; a key reads pressed when its row is low while its column is driven.
- Scan FSM states:
  - DRIVE: one-hot col_oe_o for column c; count SCAN_DIV cycles, then go to EVAL.
  - EVAL: iterate r = 0..ROWS-1, one key per cycle.
  - NEXT: release the column for 1 cycle; c wraps COLS-1→0 (frame end); return to DRIVE.
- Debounce, per key: stable bit s and counter n.
  - raw == s: n ← 0.
  - raw != s: n ← n+1. On reaching DEBOUNCE, s flips, n ← 0, and an event is generated.
- Every event is pushed in EVAL, at most one per cycle. Order is ascending row within a column, ascending column within a frame.
- FIFO full on push:
  - Without a pop: the event is dropped, ovf_o set, and s still updated.
  - With a simultaneous pop: the push is accepted.
- ovf_clr_in and an overflow in the same cycle: ovf_o stays set.
- Handshake: evt_code_o/evt_press_o hold stable while evt_valid_o=1 and !evt_ready_in. Pop when valid && ready.
- any_key_o is derived from s and updates the cycle after a flip.

## Timing
- Reset values:
  - col_oe_o=0, evt_valid_o=0, evt_code_o=0, evt_press_o=0, any_key_o=0, ovf_o=0.
  - All s=0, n=0, FSM in DRIVE, c=0, FIFO empty.
- Frame length = COLS*(SCAN_DIV+ROWS+1) cycles.
- Event latency: the EVAL cycle that flips s pushes the entry; evt_valid_o rises the next cycle (FIFO is registered, no bypass).
- Press to event: DEBOUNCE frames plus up to one frame of scan phase.
- Reset mid-scan:
  - Columns release immediately (asynchronous).
  - Queued events are lost.
  - Keys held through reset re-report as presses after DEBOUNCE frames.
- Rows are sampled only in EVAL, at least SCAN_DIV−2 cycles after the column driver changes, allowing for line settling and the synchroniser.

## Configuration
- KBD_RELEASE_EVT_EN defined:
  - Both press and release transitions are queued.
  - evt_press_o reflects direction.
- Not defined:
  - Only presses are queued; evt_press_o is tied 1.
  - Release transitions still update s and any_key_o, but never push or set ovf_o.

## Structure
- Package kbd_pkg:
  - Scan FSM state enum (DRIVE, EVAL, NEXT).
  - Event struct {code, press}.
  - Width localparam helpers for code and debounce-counter widths.
- Sub-module kbd_evt_fifo: synchronous FIFO parametrised by depth and the event struct; full/empty flags; push-when-full-with-pop allowed.

## Test plan
- Single press: COLS=11, ROWS=4, DEBOUNCE=3; hold col3/row2 low → one event code=14, press=1 after 3 frames; any_key_o=1.
- Bounce: raw press lasting 2 frames, then released → no event, any_key_o stays 0, all n return to 0.
- Release: release key 14 → code=14, press=0 with KBD_RELEASE_EVT_EN; no event without it, any_key_o→0 in both builds.
- Same column, two keys: col5 rows 0 and 3 pressed in one frame → events 20 then 23 on consecutive EVAL cycles.
- Overflow: FIFO_DEPTH=4, evt_ready_in=0, 5 distinct presses → 4 events in press order, ovf_o=1; ovf_clr_in pulse clears it.
- Reset mid-frame: assert rst_n_in during EVAL with events queued → all outputs at reset values next cycle; a held key re-reports press after DEBOUNCE frames.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and width helpers for the keyboard matrix scanner.
package kbd_pkg;

    // Widest key code the engine supports (32 columns x 8 rows).
    localparam int KBD_CODE_MAX_W = 8;

    typedef enum logic [1:0] {
        DRIVE = 2'd0,
        EVAL  = 2'd1,
        NEXT  = 2'd2
    } scan_state_e;

    // One queued key transition.
    typedef struct packed {
        logic [KBD_CODE_MAX_W-1:0] code;
        logic                      press;
    } kbd_evt_t;

    // Bits needed for a key code col*rows + row.
    function automatic int code_width(input int cols, input int rows);
        return (cols * rows > 1) ? $clog2(cols * rows) : 1;
    endfunction

    // Bits needed for a debounce counter that must be able to hold DEBOUNCE.
    function automatic int dbc_width(input int debounce);
        return (debounce > 0) ? $clog2(debounce + 1) : 1;
    endfunction

endpackage

// File: rtl/kbd_matrix_scan_if.sv
// kbd_matrix_scan_if: key-event valid/ready stream from the scanner to its consumer.
interface kbd_matrix_scan_if #(
    parameter int CODE_W = 6
);
    logic              evt_valid_o;
    logic              evt_ready_in;
    logic [CODE_W-1:0] evt_code_o;
    logic              evt_press_o;

    modport master (
        output evt_valid_o,
        output evt_code_o,
        output evt_press_o,
        input  evt_ready_in
    );

    modport slave (
        input  evt_valid_o,
        input  evt_code_o,
        input  evt_press_o,
        output evt_ready_in
    );
endinterface

// File: rtl/kbd_evt_fifo.sv
// kbd_evt_fifo: small registered FIFO for key events. A push into a full FIFO
// is accepted when a pop happens in the same cycle (the freed slot is reused).
module kbd_evt_fifo
    import kbd_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = kbd_evt_t
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);
    localparam int AW = $clog2(DEPTH);

    T           r_mem [DEPTH];
    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic       w_push_ok;
    logic       w_pop_ok;

    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_data    = r_mem[r_rd[AW-1:0]];

    // Read/write pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + 1'b1;
            if (w_pop_ok)  r_rd <= r_rd + 1'b1;
        end
    end

    // Storage; contents are don't-care while empty, so no reset needed.
    always_ff @(posedge clk_in) begin
        if (w_push_ok) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/kbd_matrix_scan.sv
// kbd_matrix_scan: drives one column at a time, debounces every key
// independently and queues key transitions into an event FIFO.
// Build option: define KBD_RELEASE_EVT_EN to queue releases as well as presses;
// otherwise only presses are queued and evt_press_o is tied high.
//
// state | meaning
// DRIVE | column r_col driven low, settling timer r_div counting down
// EVAL  | row r_row of the driven column debounced, one key per cycle
// NEXT  | all columns released for one cycle, column index advances/wraps
module kbd_matrix_scan
    import kbd_pkg::*;
#(
    parameter int COLS       = 11,
    parameter int ROWS       = 4,
    parameter int SCAN_DIV   = 16,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    output logic [COLS-1:0]  col_oe_o,
    input  logic [ROWS-1:0]  rows_in,
    kbd_matrix_scan_if.master evt_if,
    output logic             any_key_o,
    output logic             ovf_o,
    input  logic             ovf_clr_in
);
    localparam int NKEYS  = COLS * ROWS;
    localparam int CODE_W = code_width(COLS, ROWS);
    localparam int DBC_W  = dbc_width(DEBOUNCE);
    localparam int CW     = $clog2(COLS);
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    scan_state_e       r_state, w_state_nxt;
    logic [CW-1:0]     r_col, w_col_nxt;
    logic [DW-1:0]     r_div, w_div_nxt;
    logic [RW-1:0]     r_row, w_row_nxt;
    logic [COLS-1:0]   r_col_oe, w_col_oe_nxt;
    logic [ROWS-1:0]   r_sync1, r_sync2;
    logic              r_stable [NKEYS];
    logic [DBC_W-1:0]  r_cnt [NKEYS];
    logic              r_ovf;

    logic [CODE_W-1:0] w_key;
    logic              w_raw;
    logic              w_cur_s;
    logic [DBC_W-1:0]  w_cur_n;
    logic              w_flip;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_any;
    kbd_evt_t          w_evt;
    kbd_evt_t          w_head;
    logic              w_unused;

    // Two-flop synchroniser for the asynchronous row lines (idle high).
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= rows_in;
            r_sync2 <= r_sync1;
        end
    end

    // Scan FSM state, counters and registered column enables.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state  <= DRIVE;
            r_col    <= '0;
            r_div    <= DW'(SCAN_DIV - 1);
            r_row    <= '0;
            r_col_oe <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_col    <= w_col_nxt;
            r_div    <= w_div_nxt;
            r_row    <= w_row_nxt;
            r_col_oe <= w_col_oe_nxt;
        end
    end

    // Next-state logic; column enables follow the next state so they line up
    // with DRIVE/EVAL and drop during NEXT.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_div_nxt   = r_div;
        w_row_nxt   = r_row;
        case (r_state)
            DRIVE: begin
                if (r_div == '0) begin
                    w_state_nxt = EVAL;
                    w_row_nxt   = '0;
                end else begin
                    w_div_nxt = r_div - 1'b1;
                end
            end
            EVAL: begin
                if (r_row == RW'(ROWS - 1)) w_state_nxt = NEXT;
                else                        w_row_nxt   = r_row + 1'b1;
            end
            NEXT: begin
                w_state_nxt = DRIVE;
                w_div_nxt   = DW'(SCAN_DIV - 1);
                w_col_nxt   = (r_col == CW'(COLS - 1)) ? '0 : r_col + 1'b1;
            end
            default: w_state_nxt = DRIVE;
        endcase
        w_col_oe_nxt = (w_state_nxt == NEXT) ? '0 : (COLS'(1) << w_col_nxt);
    end

    assign col_oe_o = r_col_oe;

    // Debounce decision for the key currently under evaluation.
    always_comb begin
        w_key   = CODE_W'(r_col * ROWS + r_row);
        w_raw   = ~r_sync2[r_row];
        w_cur_s = r_stable[w_key];
        w_cur_n = r_cnt[w_key];
        w_flip  = (r_state == EVAL) && (w_raw != w_cur_s) &&
                  (w_cur_n == DBC_W'(DEBOUNCE - 1));
        w_evt       = '0;
        w_evt.code  = KBD_CODE_MAX_W'(w_key);
        w_evt.press = ~w_cur_s;
    end

`ifdef KBD_RELEASE_EVT_EN
    assign w_push = w_flip;
`else
    assign w_push = w_flip && !w_cur_s;
`endif

    // Per-key stable state and persistence counter, touched only in EVAL.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int k = 0; k < NKEYS; k++) begin
                r_stable[k] <= 1'b0;
                r_cnt[k]    <= '0;
            end
        end else if (r_state == EVAL) begin
            if (w_raw == w_cur_s) begin
                r_cnt[w_key] <= '0;
            end else if (w_flip) begin
                r_stable[w_key] <= ~w_cur_s;
                r_cnt[w_key]    <= '0;
            end else begin
                r_cnt[w_key] <= w_cur_n + 1'b1;
            end
        end
    end

    // OR of all debounced states; follows the stable bits one cycle after a flip.
    always_comb begin
        w_any = 1'b0;
        for (int k = 0; k < NKEYS; k++) w_any = w_any | r_stable[k];
    end

    assign any_key_o = w_any;

    kbd_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (kbd_evt_t)
    ) u_fifo (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .i_push   (w_push),
        .i_data   (w_evt),
        .i_pop    (w_pop),
        .o_data   (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign w_pop              = !w_empty && evt_if.evt_ready_in;
    assign evt_if.evt_valid_o = !w_empty;
    assign evt_if.evt_code_o  = w_empty ? '0 : w_head.code[CODE_W-1:0];
`ifdef KBD_RELEASE_EVT_EN
    assign evt_if.evt_press_o = w_empty ? 1'b0 : w_head.press;
`else
    assign evt_if.evt_press_o = 1'b1;
`endif
    assign w_unused = ^{w_head.code, w_head.press};

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)                     r_ovf <= 1'b0;
        else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
        else if (ovf_clr_in)               r_ovf <= 1'b0;
    end

    assign ovf_o = r_ovf;

endmodule
